// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg
//   Shared definitions for the program-ROM controller: controller state
//   encoding, default ROM geometry and default load base address.
package prog_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FDONE = 3'd2,
    LOAD  = 3'd3,
    LEXIT = 3'd4
  } state_e;

  localparam int unsigned ADDR_W_DEF    = 15;
  localparam int unsigned ROM_BYTES     = 1 << ADDR_W_DEF;
  localparam int unsigned LOAD_BASE_DEF = 0;

endpackage

// File: rtl/prog_mem_ctrl_ld_addr_counter.sv
// ld_addr_counter
//   Write-address and byte counter for a load session.
//   Ports:
//     clk, clr_n  - clock, synchronous active-low reset
//     load_base   - restart: address <= LOAD_BASE, count <= 0, full <= 0
//     inc         - one byte was written at the current address
//     addr        - current ROM write address
//     count       - bytes written since the last restart
//     full        - the byte at the top ROM address has been written
import prog_mem_pkg::*;

module ld_addr_counter #(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load_base,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] TOP  = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    if (load_base) begin
      addr_d  = BASE;
      count_d = '0;
      full_d  = 1'b0;
    end else if (inc && !full_q) begin
      count_d = count_q + 1'b1;
      // Hold the address at the top instead of wrapping, so nothing can
      // ever point a stray write back at address 0.
      if (addr_q == TOP) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      addr_q  <= BASE;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign addr  = addr_q;
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl
//   Sequencer/arbiter sharing a dual-read, single-write program ROM between
//   CPU instruction fetch (16-bit word from two byte ports) and a byte-stream
//   program loader. The loader wins ties; the CPU is stalled while loading.
//   Ports:
//     clk, clr_n                      - clock, synchronous active-low reset
//     fetch_req, pc                   - CPU fetch request / word address
//     instr, instr_valid              - fetched word, one-cycle valid pulse
//     cpu_stall                       - a load session owns the ROM
//     ld_req, ld_valid, ld_data       - loader session / byte handshake in
//     ld_ready, ld_done               - byte accept, end-of-session pulse
//     ld_overflow, ld_count           - sticky overflow, bytes written
//     rom_addr_a/b, rom_q_a/b         - ROM read ports (high/low byte)
//     rom_write_addr, rom_data,rom_we - ROM write port
//     rom_en_reg, rom_clr_reg_n       - ROM output register enable / clear
import prog_mem_pkg::*;

module prog_mem_ctrl #(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-2:0] pc,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_overflow,
  output logic [ADDR_W:0]   ld_count,
  output logic [ADDR_W-1:0] rom_addr_a,
  output logic [ADDR_W-1:0] rom_addr_b,
  input  logic [7:0]        rom_q_a,
  input  logic [7:0]        rom_q_b,
  output logic [ADDR_W-1:0] rom_write_addr,
  output logic [7:0]        rom_data,
  output logic              rom_we,
  output logic              rom_en_reg,
  output logic              rom_clr_reg_n
);

  state_e            state_q, state_d;
  logic [ADDR_W-2:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              ovf_q, ovf_d;
  logic              clr_hold_q, clr_hold_d;

  logic              cnt_load;
  logic              cnt_inc;
  logic              cnt_full;

  ld_addr_counter #(
    .ADDR_W    (ADDR_W),
    .LOAD_BASE (LOAD_BASE)
  ) u_ld_addr_counter (
    .clk       (clk),
    .clr_n     (clr_n),
    .load_base (cnt_load),
    .inc       (cnt_inc),
    .addr      (rom_write_addr),
    .count     (ld_count),
    .full      (cnt_full)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ovf_d       = ovf_q;
    clr_hold_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    instr       = instr_q;
    instr_valid = 1'b0;
    rom_en_reg  = 1'b0;
    rom_we      = 1'b0;
    ld_ready    = 1'b0;
    ld_done     = 1'b0;
    cpu_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_req) begin
          state_d  = LOAD;
          cnt_load = 1'b1;
          ovf_d    = 1'b0;
        end else if (fetch_req) begin
          state_d = FETCH;
          pc_d    = pc;
        end
      end
      FETCH: begin
        rom_en_reg = 1'b1;
        state_d    = FDONE;
      end
      FDONE: begin
        // Present the ROM output directly this cycle and keep a copy so
        // instr stays stable until the next fetch completes.
        instr       = {rom_q_a, rom_q_b};
        instr_d     = {rom_q_a, rom_q_b};
        instr_valid = 1'b1;
        state_d     = IDLE;
      end
      LOAD: begin
        cpu_stall = 1'b1;
        // Gating with ld_req refuses a byte offered in the exit cycle.
        ld_ready  = ld_req && !cnt_full;
        if (ld_valid && ld_ready) begin
          rom_we  = 1'b1;
          cnt_inc = 1'b1;
        end
        if (ld_valid && cnt_full) begin
          ovf_d = 1'b1;
        end
        if (!ld_req) begin
          state_d = LEXIT;
        end
      end
      LEXIT: begin
        cpu_stall = 1'b1;
        ld_done   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      ovf_q      <= 1'b0;
      clr_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ovf_q      <= ovf_d;
      clr_hold_q <= clr_hold_d;
    end
  end

  assign rom_addr_a    = {pc_q, 1'b1};
  assign rom_addr_b    = {pc_q, 1'b0};
  assign rom_data      = ld_data;
  assign ld_overflow   = ovf_q;
  // Clear the ROM output register coming out of reset and after every load,
  // so an instruction read before the new image cannot leak out.
  assign rom_clr_reg_n = !(clr_hold_q || (state_q == LEXIT));

endmodule

// File: tb/tb_prog_mem_ctrl.sv
module tb_prog_mem_ctrl;
  import prog_mem_pkg::*;

  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr_n, fetch_req, ld_req, ld_req1, ld_valid;
  logic [AW-2:0] pc;
  logic [7:0]    ld_data;

  // DUT 0: LOAD_BASE = 0
  logic [15:0]   instr;
  logic          instr_valid, cpu_stall, ld_ready, ld_done, ld_overflow;
  logic [AW:0]   ld_count;
  logic [AW-1:0] rom_addr_a, rom_addr_b, rom_write_addr;
  logic [7:0]    rom_q_a, rom_q_b, rom_data;
  logic          rom_we, rom_en_reg, rom_clr_reg_n;

  // DUT 1: LOAD_BASE = 0x7FFE, loader only
  logic [15:0]   instr1;
  logic          instr_valid1, cpu_stall1, ld_ready1, ld_done1, ld_overflow1;
  logic [AW:0]   ld_count1;
  logic [AW-1:0] rom_addr_a1, rom_addr_b1, rom_write_addr1;
  logic [7:0]    rom_q_a1, rom_q_b1, rom_data1;
  logic          rom_we1, rom_en_reg1, rom_clr_reg_n1;

  prog_mem_ctrl #(.ADDR_W(AW), .LOAD_BASE(0)) dut (
    .clk(clk), .clr_n(clr_n), .fetch_req(fetch_req), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_overflow(ld_overflow),
    .ld_count(ld_count), .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b), .rom_write_addr(rom_write_addr),
    .rom_data(rom_data), .rom_we(rom_we), .rom_en_reg(rom_en_reg),
    .rom_clr_reg_n(rom_clr_reg_n)
  );

  prog_mem_ctrl #(.ADDR_W(AW), .LOAD_BASE(32'h7FFE)) dut1 (
    .clk(clk), .clr_n(clr_n), .fetch_req(1'b0), .pc(pc),
    .instr(instr1), .instr_valid(instr_valid1), .cpu_stall(cpu_stall1),
    .ld_req(ld_req1), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready1), .ld_done(ld_done1), .ld_overflow(ld_overflow1),
    .ld_count(ld_count1), .rom_addr_a(rom_addr_a1), .rom_addr_b(rom_addr_b1),
    .rom_q_a(rom_q_a1), .rom_q_b(rom_q_b1), .rom_write_addr(rom_write_addr1),
    .rom_data(rom_data1), .rom_we(rom_we1), .rom_en_reg(rom_en_reg1),
    .rom_clr_reg_n(rom_clr_reg_n1)
  );

  // ROM models: registered dual read, single write, clear beats enable.
  logic [7:0] mem0 [ROM_BYTES];
  logic [7:0] mem1 [ROM_BYTES];

  always @(posedge clk) begin
    if (rom_we) mem0[rom_write_addr] <= rom_data;
    if (!rom_clr_reg_n) begin
      rom_q_a <= 8'h00;
      rom_q_b <= 8'h00;
    end else if (rom_en_reg) begin
      rom_q_a <= mem0[rom_addr_a];
      rom_q_b <= mem0[rom_addr_b];
    end
  end

  always @(posedge clk) begin
    if (rom_we1) mem1[rom_write_addr1] <= rom_data1;
    if (!rom_clr_reg_n1) begin
      rom_q_a1 <= 8'h00;
      rom_q_b1 <= 8'h00;
    end else if (rom_en_reg1) begin
      rom_q_a1 <= mem1[rom_addr_a1];
      rom_q_b1 <= mem1[rom_addr_b1];
    end
  end

  int checks = 0;
  int errors = 0;
  int done_seen0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [15:0] instr; logic [AW-2:0] pc; } fetch_t;
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [AW:0] count; logic ovf; } done_t;

  fetch_t q_fetch[$];
  wr_t    q_wr0[$];
  wr_t    q_wr1[$];
  done_t  q_done0[$];
  done_t  q_done1[$];

  fetch_t mf;
  wr_t    mw;
  done_t  md;

  // Monitor / scoreboard: compares whenever a DUT presents an event.
  always @(negedge clk) begin
    if (clr_n) begin
      if (rom_en_reg) begin
        if (q_fetch.size() == 0) chk("unexpected_fetch", 1, 0);
        else begin
          chk("rom_addr_a", rom_addr_a, {q_fetch[0].pc, 1'b1});
          chk("rom_addr_b", rom_addr_b, {q_fetch[0].pc, 1'b0});
          chk("stall_in_fetch", cpu_stall, 0);
          chk("we_in_fetch", rom_we, 0);
        end
      end
      if (instr_valid) begin
        if (q_fetch.size() == 0) chk("unexpected_instr", 1, 0);
        else begin
          mf = q_fetch.pop_front();
          chk("instr", instr, mf.instr);
        end
      end
      if (rom_we) begin
        if (q_wr0.size() == 0) chk("unexpected_write", rom_write_addr, 32'hFFFF_FFFF);
        else begin
          mw = q_wr0.pop_front();
          chk("write_addr", rom_write_addr, mw.addr);
          chk("write_data", rom_data, mw.data);
          chk("stall_in_write", cpu_stall, 1);
        end
      end
      if (ld_done) begin
        done_seen0++;
        if (q_done0.size() == 0) chk("unexpected_ld_done", 1, 0);
        else begin
          md = q_done0.pop_front();
          chk("done_count", ld_count, md.count);
          chk("done_overflow", ld_overflow, md.ovf);
          chk("done_clr_reg_n", rom_clr_reg_n, 0);
          chk("done_stall", cpu_stall, 1);
        end
      end
      if (rom_we1) begin
        if (q_wr1.size() == 0) chk("unexpected_write1", rom_write_addr1, 32'hFFFF_FFFF);
        else begin
          mw = q_wr1.pop_front();
          chk("write1_addr", rom_write_addr1, mw.addr);
          chk("write1_data", rom_data1, mw.data);
        end
      end
      if (ld_done1) begin
        if (q_done1.size() == 0) chk("unexpected_ld_done1", 1, 0);
        else begin
          md = q_done1.pop_front();
          chk("done1_count", ld_count1, md.count);
          chk("done1_overflow", ld_overflow1, md.ovf);
          chk("done1_clr_reg_n", rom_clr_reg_n1, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [AW-2:0] pc_v, input logic [15:0] exp);
    q_fetch.push_back({exp, pc_v});
    pc        = pc_v;
    fetch_req = 1'b1;
  endtask

  task automatic finish_fetch();
    int n;
    n = 0;
    while (!rom_en_reg && n < 30) begin tick(); n++; end
    if (!rom_en_reg) chk("fetch_start_timeout", 0, 1);
    fetch_req = 1'b0;
    pc        = ~pc;  // later pc changes must not affect the fetch in flight
    n = 0;
    while (!instr_valid && n < 5) begin tick(); n++; end
    if (!instr_valid) chk("instr_valid_timeout", 0, 1);
    chk("fetch_to_valid_cycles", n, 1);
    tick();
  endtask

  task automatic load(input int which, input logic [63:0] bv, input int n,
                      input int n_acc, input logic [AW-1:0] base, input logic exp_ovf);
    int k;
    if (which == 0) ld_req = 1'b1; else ld_req1 = 1'b1;
    k = 0;
    while (!(which == 0 ? ld_ready : ld_ready1) && k < 10) begin tick(); k++; end
    if (!(which == 0 ? ld_ready : ld_ready1)) chk("ld_ready_timeout", 0, 1);
    chk("cpu_stall_load", (which == 0) ? cpu_stall : cpu_stall1, 1);
    for (int i = 0; i < n; i++) begin
      if (i < n_acc) begin
        if (which == 0) q_wr0.push_back({AW'(base + AW'(i)), bv[8*i +: 8]});
        else            q_wr1.push_back({AW'(base + AW'(i)), bv[8*i +: 8]});
      end
      ld_valid = 1'b1;
      ld_data  = bv[8*i +: 8];
      tick();
    end
    ld_valid = 1'b0;
    if (n > n_acc) begin
      chk("ld_ready_after_top", (which == 0) ? ld_ready : ld_ready1, 0);
      chk("ld_overflow_set", (which == 0) ? ld_overflow : ld_overflow1, 1);
    end
    if (which == 0) begin
      q_done0.push_back({(AW+1)'(n_acc), exp_ovf});
      ld_req = 1'b0;
    end else begin
      q_done1.push_back({(AW+1)'(n_acc), exp_ovf});
      ld_req1 = 1'b0;
    end
    k = 0;
    while (!(which == 0 ? ld_done : ld_done1) && k < 5) begin tick(); k++; end
    if (!(which == 0 ? ld_done : ld_done1)) chk("ld_done_timeout", 0, 1);
    tick();
    chk("clr_reg_n_after_exit", (which == 0) ? rom_clr_reg_n : rom_clr_reg_n1, 1);
    chk("stall_after_exit", (which == 0) ? cpu_stall : cpu_stall1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    for (int i = 0; i < ROM_BYTES; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[32'h20] = 8'h0C;
    mem0[32'h21] = 8'h94;
    clr_n = 1'b0; fetch_req = 1'b0; ld_req = 1'b0; ld_req1 = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; pc = '0;
    tick(); tick();

    // Reset state
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_rom_en_reg", rom_en_reg, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_ld_overflow", ld_overflow, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_instr", instr, 0);
    chk("rst_write_addr", rom_write_addr, 0);
    chk("rst_write_addr1", rom_write_addr1, 32'h7FFE);
    chk("rst_clr_reg_n", rom_clr_reg_n, 0);
    clr_n = 1'b1;
    tick();
    chk("post_rst_clr_reg_n", rom_clr_reg_n, 1);
    $display("reset checked");

    // Basic fetch
    start_fetch(14'h0010, 16'h940C);
    finish_fetch();
    $display("fetch pc=0x0010 done");

    // Four-byte load, then read back
    load(0, 64'hDDCCBBAA, 4, 4, '0, 1'b0);
    chk("ld_count_after_load", ld_count, 4);
    $display("load AA BB CC DD done");
    start_fetch(14'h0000, 16'hBBAA);
    finish_fetch();
    $display("fetch pc=0 done");
    start_fetch(14'h0001, 16'hDDCC);
    finish_fetch();
    $display("fetch pc=1 done");

    // Loader and fetch request in the same cycle: load first
    start_fetch(14'h0000, 16'hA55A);
    load(0, 64'hA55A, 2, 2, '0, 1'b0);
    finish_fetch();
    $display("simultaneous load+fetch done");

    // Fill to the top of ROM on the second instance
    load(1, 64'h332211, 3, 2, 15'h7FFE, 1'b1);
    chk("ld_count1_after_fill", ld_count1, 2);
    $display("fill test done");

    // Reset in the middle of a load session
    done_before = done_seen0;
    ld_req = 1'b1;
    begin
      int k;
      k = 0;
      while (!ld_ready && k < 10) begin tick(); k++; end
      if (!ld_ready) chk("ld_ready_timeout_rst", 0, 1);
    end
    q_wr0.push_back({15'h0000, 8'h11});
    q_wr0.push_back({15'h0001, 8'h22});
    ld_valid = 1'b1; ld_data = 8'h11; tick();
    ld_data = 8'h22; tick();
    ld_valid = 1'b0; ld_req = 1'b0; clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    chk("midrst_cpu_stall", cpu_stall, 0);
    chk("midrst_ld_count", ld_count, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    tick(); tick();
    chk("midrst_no_ld_done", done_seen0, done_before);
    $display("reset mid-load done");
    start_fetch(14'h0000, 16'h2211);
    finish_fetch();
    $display("fetch after reset done");

    tick(); tick();
    chk("fetch_queue_empty", q_fetch.size(), 0);
    chk("wr0_queue_empty", q_wr0.size(), 0);
    chk("wr1_queue_empty", q_wr1.size(), 0);
    chk("done0_queue_empty", q_done0.size(), 0);
    chk("done1_queue_empty", q_done1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
Sequencer and arbiter for the dual-read-port, single-write-port program ROM (32 K x 8, registered read outputs).
Shares the ROM between two requesters:
- CPU instruction fetch: one 16-bit word per request, built from two byte reads in one cycle.
- Byte-stream program loader: UART/JTAG-style host writing a new image.
Drives ROM addresses, write strobe, output-register enable and output-register clear; stalls the CPU while loading.

Parameters:
ADDR_W, 15, ROM byte-address width; word address (pc) is ADDR_W-1 bits
LOAD_BASE, 0, first byte address written by a load session

Ports:
clk  in  1  system clock, all logic on rising edge
clr_n  in  1  synchronous active-low reset
fetch_req  in  1  CPU requests the instruction at pc (level; sampled in IDLE)
pc  in  ADDR_W-1  word address of requested instruction
instr  out  16  fetched instruction {high byte, low byte}
instr_valid  out  1  one-cycle pulse; instr is valid this cycle
cpu_stall  out  1  high while a load session owns the ROM
ld_req  in  1  loader session request (level; held high for the whole session)
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_ready  out  1  controller accepts ld_data this cycle
ld_done  out  1  one-cycle pulse at session end
ld_overflow  out  1  sticky; session tried to write past top of ROM; cleared at next session start
ld_count  out  ADDR_W+1  bytes written in current/last session
rom_addr_a  out  ADDR_W  to ROM port A (high byte) = {pc,1'b1}
rom_addr_b  out  ADDR_W  to ROM port B (low byte) = {pc,1'b0}
rom_q_a  in  8  ROM registered output A
rom_q_b  in  8  ROM registered output B
rom_write_addr  out  ADDR_W  ROM write address
rom_data  out  8  ROM write data (= ld_data)
rom_we  out  1  ROM write enable
rom_en_reg  out  1  ROM output register enable
rom_clr_reg_n  out  1  ROM output register clear, active-low

Behaviour:
- Reset (clr_n=0 at edge):
  - State IDLE.
  - All strobes low: instr_valid, rom_we, ld_ready, ld_done, rom_en_reg.
  - cpu_stall=0, ld_overflow=0, ld_count=0, instr=0, rom_write_addr=LOAD_BASE.
  - rom_clr_reg_n=0 for the reset cycle, 1 afterwards.
  - Reset mid-load abandons the session; bytes already written stay in ROM.
- States: IDLE, FETCH, FDONE, LOAD, LEXIT.
- IDLE:
  - ld_req=1 -> LOAD. Loader wins if ld_req and fetch_req are both high. Entry clears ld_count and ld_overflow and sets rom_write_addr=LOAD_BASE.
  - Else fetch_req=1 -> FETCH.
- FETCH:
  - rom_en_reg=1; rom_addr_a/b driven from pc, which is captured into an internal register on entry. The captured pc is held through FDONE; later pc changes are ignored.
  - Next state is FDONE unconditionally.
- FDONE:
  - instr={rom_q_a,rom_q_b}, instr_valid=1, rom_en_reg=0.
  - Next state is IDLE.
  - Fetch latency: 2 cycles from the IDLE cycle sampling fetch_req to the instr_valid pulse. Back-to-back throughput is 1 instruction per 3 cycles.
- LOAD:
  - cpu_stall=1.
  - ld_ready=1 while rom_write_addr has not passed the top of ROM.
  - Each cycle with ld_valid&ld_ready:
    - rom_we=1, rom_data=ld_data, rom_write_addr = current address.
    - Address increments, ld_count increments.
  - After writing byte 2^ADDR_W-1: ld_ready=0 for the rest of the session.
  - Any later ld_valid sets ld_overflow=1; the byte is dropped with no write.
  - ld_req=0 -> LEXIT. A byte presented in that same cycle is not accepted (ld_ready=0).
- LEXIT:
  - rom_clr_reg_n=0 for one cycle to flush any stale instruction register.
  - ld_done=1, cpu_stall stays 1 this cycle.
  - Next state is IDLE.
- fetch_req during LOAD/LEXIT is ignored; the CPU must hold it and it is serviced from IDLE.
- rom_we is never high in FETCH/FDONE, so reads and writes never overlap.

Decomposition:
- Package prog_mem_pkg holds the state enum (IDLE, FETCH, FDONE, LOAD, LEXIT), the ROM_BYTES constant (2^ADDR_W) and the LOAD_BASE default.
- One natural sub-module, ld_addr_counter: write-address/byte counter with increment, load-to-base and top-of-ROM flag.

Test Plan:
- Reset then fetch_req=1, pc=0x0010, ROM[0x20]=0x0C, ROM[0x21]=0x94 -> instr_valid 2 cycles later with instr=0x940C; rom_addr_a=0x0021, rom_addr_b=0x0020.
- ld_req=1, stream 4 bytes 0xAA,0xBB,0xCC,0xDD, then ld_req=0:
  - Writes land at 0..3; ld_count=4; ld_done pulses once; rom_clr_reg_n low one cycle.
  - A subsequent fetch of pc=0 returns 0xBBAA and pc=1 returns 0xDDCC.
- ld_req and fetch_req rise in the same cycle -> load runs first with cpu_stall=1; fetch completes after ld_done with correct post-load data.
- Fill test: LOAD_BASE=0x7FFE, stream 3 bytes -> 2 writes (0x7FFE, 0x7FFF); ld_ready drops; ld_overflow=1; ld_count=2; no write at 0x0000.
- clr_n=0 asserted after 2 of 5 load bytes -> state IDLE, cpu_stall=0, ld_count=0, ld_done not pulsed; ROM bytes 0..1 retain the new values.
